tree_plru: RTL and testbench
============================

# tree_plru

Parametrised tree pseudo-LRU replacement tracker for the set-associative caches in the MIPS core. It generalises the fixed 4-way, single-set tracker to any power-of-two associativity and any number of sets, with one tree of state per set. It prefers invalid ways for victim selection and supports a multi-cycle flush sweep, so the state array can map to distributed RAM. It sits beside the cache tag array: the cache touches ways on hit or fill and queries the victim on a miss.

## Interface
- ASSOCIATIVITY, default 4: ways per set; power of two, at least 2. WAY_W = $clog2(ASSOCIATIVITY).
- NUM_SETS, default 64: number of sets; power of two, at least 2. SET_W = $clog2(NUM_SETS).
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- touch_en  input  1  mark touch_way of touch_set as most recently used this cycle.
- touch_set  input  SET_W  set being touched.
- touch_way  input  WAY_W  way being touched.
- query_set  input  SET_W  set whose victim is reported.
- valid_mask  input  ASSOCIATIVITY  per-way valid bits of query_set, from the tag array.
- victim_way  output  WAY_W  combinational victim for query_set.
- victim_invalid  output  1  high when victim_way was chosen because a way is invalid.
- flush_req  input  1  one-cycle request to clear all tree state.
- flush_busy  output  1  high while the clear sweep runs; touches are dropped.

## Operation
- Per set: ASSOCIATIVITY-1 node bits in heap order. Node 1 is the root; node n has children 2n and 2n+1. Leaves map to ways 0..A-1 left to right.
- Node bit 0 means the LRU side is left (lower ways); 1 means right.
- Victim walk: start at root, follow each node bit to a leaf, giving the tree victim.
- Touch: for every node on the path to touch_way, set the bit to point away from that way (1 if the way is in the left subtree, else 0). Off-path nodes hold. Repeating a touch to the same way is idempotent.
- Invalid priority: if any valid_mask bit is 0, victim_way is the lowest-index invalid way and victim_invalid = 1. Otherwise victim_way is the tree victim and victim_invalid = 0.
- Sweep FSM has two states:
  - IDLE to SWEEP on flush_req, or on reset release.
  - In SWEEP, a set pointer clears one set per cycle, from 0 to NUM_SETS-1, then returns to IDLE.
- flush_req during SWEEP is ignored; the sweep does not restart.
- Collisions:
  - The sweep write wins over any touch.
  - While flush_busy = 1, all touches are dropped, not queued.
  - flush_req and touch_en in the same IDLE cycle: the touch is applied, then the sweep starts.
- Query is a pure read and is legal during SWEEP. Sets not yet cleared still report their old state.

## Timing
- Reset (rst_n low at an edge): FSM enters SWEEP, pointer = 0, flush_busy = 1. Node state is not cleared while rst_n is held low.
- After release, sets 0..NUM_SETS-1 clear on the next NUM_SETS edges. flush_busy falls after the edge that clears the last set, so it is high for exactly NUM_SETS cycles after release.
- Reset asserted mid-sweep restarts the sweep at set 0.
- flush_req sampled at edge N: flush_busy is high from N+1. Set k clears at edge N+1+k, for k = 0..NUM_SETS-1. flush_busy falls after edge N+NUM_SETS.
- Touch latency: a touch at edge N is visible on victim_way for that set from edge N onward, i.e. in the following cycle.
- Same-cycle touch and query of the same set: victim_way reflects pre-touch state. There is no bypass.
- victim_way and victim_invalid are combinational from node state, query_set and valid_mask, with no extra cycle.
- Pointer wraps from NUM_SETS-1 to IDLE; it never wraps back to 0 inside a sweep.

## Test plan
- A=4, NUM_SETS=4, all valid. After the reset sweep, victim(set 0) = 0. Touch 0, then victim = 2. Touch 2, then 1. Touch 1, then 3. Touch 3, then 0.
- Set independence: touch set 1 way 0, then victim(set 1) = 2 while victim(set 2) = 0. Touch set 3 way 3, then victim(set 3) = 0 and set 1 is unchanged.
- Invalid priority, all tree bits pointing to way 2: valid_mask = 4'b1101 gives victim 1 with victim_invalid = 1. 4'b0110 gives 0. 4'b1111 gives 2 with victim_invalid = 0.
- Flush: dirty all sets, pulse flush_req. flush_busy is high for exactly 4 cycles. Set k reads victim 0 from cycle k+1 on. A touch issued mid-sweep has no effect, and a second flush_req mid-sweep does not extend busy.
- Reset mid-sweep at pointer 2: after release, flush_busy is high for 4 more cycles and all sets read victim 0.
- A=8, NUM_SETS=2 from reset: touching ways 0..7 in order leaves victim = 0. Touch 0 alone from reset gives victim 4.

Source files
------------

// File: rtl/tree_plru.sv
// Tree pseudo-LRU replacement tracker with one tree per set, invalid-way priority
// and a one-set-per-cycle clear sweep after reset or flush.
module tree_plru #(
  parameter int ASSOCIATIVITY = 4,
  parameter int NUM_SETS      = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             touch_en,
  input  logic [$clog2(NUM_SETS)-1:0]      touch_set,
  input  logic [$clog2(ASSOCIATIVITY)-1:0] touch_way,
  input  logic [$clog2(NUM_SETS)-1:0]      query_set,
  input  logic [ASSOCIATIVITY-1:0]         valid_mask,
  output logic [$clog2(ASSOCIATIVITY)-1:0] victim_way,
  output logic                             victim_invalid,
  input  logic                             flush_req,
  output logic                             flush_busy
);

  localparam int WAY_W = $clog2(ASSOCIATIVITY);
  localparam int SET_W = $clog2(NUM_SETS);

  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       SWEEP    = 1'b1;
  localparam logic [SET_W-1:0] SET_ZERO = {SET_W{1'b0}};
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(NUM_SETS - 1);

  // Node n of a set lives at bit n (heap order, root = 1); bit 0 is a constant-zero spare
  // so node numbers index the word directly.
  logic [ASSOCIATIVITY-1:0] tree_r [NUM_SETS];

  logic [0:0]               state_r;
  logic [SET_W-1:0]         ptr_r;
  logic [ASSOCIATIVITY-1:0] query_bits_s;
  logic [ASSOCIATIVITY-1:0] touch_bits_s;
  logic [WAY_W:0]           walk_s;
  logic [WAY_W:0]           path_s;
  logic [WAY_W-1:0]         tree_way_s;
  logic [WAY_W-1:0]         inv_way_s;
  logic                     wr_en_s;
  logic [SET_W-1:0]         wr_set_s;
  logic [ASSOCIATIVITY-1:0] wr_data_s;

  // Walk the queried tree from the root, following each node bit down to a leaf.
  always_comb begin
    query_bits_s = tree_r[query_set];
    walk_s       = {{WAY_W{1'b0}}, 1'b1};
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      walk_s = {walk_s[WAY_W-1:0], query_bits_s[walk_s[WAY_W-1:0]]};
    end
    tree_way_s = walk_s[WAY_W-1:0];
  end

  // Lowest-index invalid way, scanning from the top so the lowest index is written last.
  always_comb begin
    inv_way_s = {WAY_W{1'b0}};
    for (int i = ASSOCIATIVITY - 1; i >= 0; i--) begin
      if (!valid_mask[i]) begin
        inv_way_s = WAY_W'(i);
      end else begin
        inv_way_s = inv_way_s;
      end
    end
  end

  assign victim_invalid = ~(&valid_mask);
  assign victim_way     = victim_invalid ? inv_way_s : tree_way_s;
  assign flush_busy     = (state_r == SWEEP);

  // Climb from the touched leaf to the root, pointing every ancestor away from it.
  always_comb begin
    touch_bits_s = tree_r[touch_set];
    path_s       = {1'b1, touch_way};
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      touch_bits_s[path_s[WAY_W:1]] = ~path_s[0];
      path_s = {1'b0, path_s[WAY_W:1]};
    end
  end

  // Single write port: the sweep clear takes priority over a touch.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_set_s  = ptr_r;
    wr_data_s = {ASSOCIATIVITY{1'b0}};
    if (!rst_n) begin
      wr_en_s = 1'b0;
    end else if (state_r == SWEEP) begin
      wr_en_s   = 1'b1;
      wr_set_s  = ptr_r;
      wr_data_s = {ASSOCIATIVITY{1'b0}};
    end else if (touch_en) begin
      wr_en_s   = 1'b1;
      wr_set_s  = touch_set;
      wr_data_s = touch_bits_s;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Tree state array, left unreset so it can map to distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      tree_r[wr_set_s] <= wr_data_s;
    end
  end

  // Sweep control: reset or flush starts a walk over every set, one set per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= SWEEP;
      ptr_r   <= SET_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (flush_req) begin
            state_r <= SWEEP;
            ptr_r   <= SET_ZERO;
          end
        end
        SWEEP: begin
          if (ptr_r == SET_LAST) begin
            state_r <= IDLE;
            ptr_r   <= SET_ZERO;
          end else begin
            ptr_r <= ptr_r + SET_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          ptr_r   <= SET_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tree_plru.sv
// Bench for tree_plru: a 4-way/4-set and an 8-way/2-set instance checked against a
// recency-timestamp model of tree pseudo-LRU.
module tb_tree_plru;

  localparam int A0 = 4;
  localparam int S0 = 4;
  localparam int A1 = 8;
  localparam int S1 = 2;

  logic       clk;
  logic       rst_n;
  logic       a_touch_en, a_flush, a_busy, a_inv;
  logic [1:0] a_touch_set, a_touch_way, a_query_set, a_victim;
  logic [3:0] a_valid;
  logic       b_touch_en, b_flush, b_busy, b_inv;
  logic [0:0] b_touch_set, b_query_set;
  logic [2:0] b_touch_way, b_victim;
  logic [7:0] b_valid;

  int unsigned stamp [2][4][8];
  int          sweep [2];
  int unsigned now_t;
  int          passed;
  int          total;

  tree_plru #(.ASSOCIATIVITY(A0), .NUM_SETS(S0)) dut_a (
    .clk(clk), .rst_n(rst_n), .touch_en(a_touch_en), .touch_set(a_touch_set),
    .touch_way(a_touch_way), .query_set(a_query_set), .valid_mask(a_valid),
    .victim_way(a_victim), .victim_invalid(a_inv), .flush_req(a_flush), .flush_busy(a_busy)
  );

  tree_plru #(.ASSOCIATIVITY(A1), .NUM_SETS(S1)) dut_b (
    .clk(clk), .rst_n(rst_n), .touch_en(b_touch_en), .touch_set(b_touch_set),
    .touch_way(b_touch_way), .query_set(b_query_set), .valid_mask(b_valid),
    .victim_way(b_victim), .victim_invalid(b_inv), .flush_req(b_flush), .flush_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each node points away from the most recently used way below it; untouched halves go left.
  function automatic int tree_victim(int d, int s);
    int lo, size, half;
    int unsigned ml, mr;
    lo   = 0;
    size = (d == 0) ? A0 : A1;
    while (size > 1) begin
      half = size / 2;
      ml   = 0;
      mr   = 0;
      for (int i = 0; i < half; i++) begin
        if (stamp[d][s][lo + i] > ml) ml = stamp[d][s][lo + i];
        if (stamp[d][s][lo + half + i] > mr) mr = stamp[d][s][lo + half + i];
      end
      if (ml > mr) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  function automatic int exp_way(int d, int s, logic [7:0] valid);
    int assoc, w;
    assoc = (d == 0) ? A0 : A1;
    w     = -1;
    for (int i = assoc - 1; i >= 0; i--) begin
      if (!valid[i]) w = i;
    end
    if (w < 0) w = tree_victim(d, s);
    return w;
  endfunction

  function automatic logic exp_inv(int d, logic [7:0] valid);
    return (d == 0) ? !(&valid[3:0]) : !(&valid);
  endfunction

  task automatic model_edge(int d, logic ten, int ts, int tw, logic fl);
    int sets;
    sets = (d == 0) ? S0 : S1;
    if (!rst_n) begin
      sweep[d] = 0;
    end else if (sweep[d] >= 0) begin
      for (int w = 0; w < 8; w++) stamp[d][sweep[d]][w] = 0;
      sweep[d]++;
      if (sweep[d] == sets) sweep[d] = -1;
    end else begin
      if (ten) begin
        now_t++;
        stamp[d][ts][tw] = now_t;
      end
      if (fl) sweep[d] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, a_touch_en, int'(a_touch_set), int'(a_touch_way), a_flush);
    model_edge(1, b_touch_en, int'(b_touch_set), int'(b_touch_way), b_flush);
    #1;
  endtask

  task automatic test_reset();
    int fa, fb;
    rst_n = 1'b0;
    repeat (3) step();
    total++;
    if (a_busy !== 1'b1 || b_busy !== 1'b1) $display("FAIL reset_busy: a=%b b=%b expected 1 1", a_busy, b_busy);
    else passed++;
    rst_n = 1'b1;
    fa = -1;
    fb = -1;
    for (int c = 0; c < 10; c++) begin
      if (fa < 0 && a_busy === 1'b0) fa = c;
      if (fb < 0 && b_busy === 1'b0) fb = c;
      step();
    end
    total++;
    if (fa != S0) $display("FAIL reset_busy_len_a: busy cycles %0d expected %0d", fa, S0);
    else passed++;
    total++;
    if (fb != S1) $display("FAIL reset_busy_len_b: busy cycles %0d expected %0d", fb, S1);
    else passed++;
    for (int s = 0; s < S0; s++) begin
      a_query_set = 2'(s);
      b_query_set = 1'(s % S1);
      #1;
      total++;
      if (a_victim !== 2'd0 || a_inv !== 1'b0 || b_victim !== 3'd0 || b_inv !== 1'b0)
        $display("FAIL reset_clear set %0d: a=%0d/%b b=%0d/%b expected 0/0 0/0", s, a_victim, a_inv, b_victim, b_inv);
      else passed++;
    end
  endtask

  task automatic test_assoc8();
    b_query_set = 1'b0;
    b_touch_en  = 1'b1;
    b_touch_set = 1'b0;
    b_touch_way = 3'd0;
    step();
    b_touch_en = 1'b0;
    #1;
    total++;
    if (b_victim !== 3'd4 || b_victim !== 3'(exp_way(1, 0, b_valid)))
      $display("FAIL assoc8_touch0: victim %0d expected 4", b_victim);
    else passed++;
    for (int w = 0; w < A1; w++) begin
      b_touch_en  = 1'b1;
      b_touch_set = 1'b1;
      b_touch_way = 3'(w);
      step();
    end
    b_touch_en  = 1'b0;
    b_query_set = 1'b1;
    #1;
    total++;
    if (b_victim !== 3'd0 || b_victim !== 3'(exp_way(1, 1, b_valid)))
      $display("FAIL assoc8_all: victim %0d expected 0", b_victim);
    else passed++;
  endtask

  task automatic test_touch_order();
    int ways [4];
    int expv [4];
    int prev;
    ways = '{0, 2, 1, 3};
    expv = '{2, 1, 3, 0};
    prev = 0;
    a_query_set = 2'd0;
    for (int i = 0; i < 4; i++) begin
      a_touch_en  = 1'b1;
      a_touch_set = 2'd0;
      a_touch_way = 2'(ways[i]);
      #1;
      total++;
      if (a_victim !== 2'(prev)) $display("FAIL no_bypass %0d: victim %0d expected %0d", i, a_victim, prev);
      else passed++;
      step();
      a_touch_en = 1'b0;
      #1;
      total++;
      if (a_victim !== 2'(expv[i]) || a_victim !== 2'(exp_way(0, 0, {4'hF, a_valid})))
        $display("FAIL touch_order %0d: victim %0d expected %0d", i, a_victim, expv[i]);
      else passed++;
      prev = expv[i];
    end
  endtask

  task automatic test_sets();
    int qs [4];
    int ev [4];
    qs = '{1, 2, 3, 1};
    ev = '{2, 0, 0, 2};
    a_touch_en  = 1'b1;
    a_touch_set = 2'd1;
    a_touch_way = 2'd0;
    step();
    a_touch_set = 2'd3;
    a_touch_way = 2'd3;
    step();
    a_touch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_query_set = 2'(qs[i]);
      #1;
      total++;
      if (a_victim !== 2'(ev[i]) || a_victim !== 2'(exp_way(0, qs[i], {4'hF, a_valid})))
        $display("FAIL set_indep set %0d: victim %0d expected %0d", qs[i], a_victim, ev[i]);
      else passed++;
    end
  endtask

  task automatic test_invalid();
    logic [3:0] masks [3];
    int ev [3];
    logic ei [3];
    masks = '{4'b1101, 4'b0110, 4'b1111};
    ev    = '{1, 0, 2};
    ei    = '{1'b1, 1'b1, 1'b0};
    a_touch_en  = 1'b1;
    a_touch_set = 2'd2;
    a_touch_way = 2'd0;
    step();
    a_touch_en  = 1'b0;
    a_query_set = 2'd2;
    for (int i = 0; i < 3; i++) begin
      a_valid = masks[i];
      #1;
      total++;
      if (a_victim !== 2'(ev[i]) || a_inv !== ei[i])
        $display("FAIL invalid_prio %b: victim %0d/%b expected %0d/%b", masks[i], a_victim, a_inv, ev[i], ei[i]);
      else passed++;
    end
    a_valid = 4'hF;
  endtask

  task automatic test_flush();
    int busy_cnt;
    for (int s = 0; s < S0; s++) begin
      a_touch_en  = 1'b1;
      a_touch_set = 2'(s);
      a_touch_way = 2'd1;
      step();
    end
    a_touch_en = 1'b0;
    a_flush    = 1'b1;
    step();
    a_flush  = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (a_busy === 1'b1) busy_cnt++;
      total++;
      if (a_busy !== (sweep[0] >= 0)) $display("FAIL flush_busy cycle %0d: busy %b expected %b", c, a_busy, sweep[0] >= 0);
      else passed++;
      for (int s = 0; s < S0; s++) begin
        a_query_set = 2'(s);
        #1;
        total++;
        if (a_victim !== 2'(exp_way(0, s, {4'hF, a_valid})))
          $display("FAIL flush_sweep cycle %0d set %0d: victim %0d expected %0d", c, s, a_victim, exp_way(0, s, {4'hF, a_valid}));
        else passed++;
      end
      a_touch_en  = (c == 1);
      a_touch_set = 2'd0;
      a_touch_way = 2'd0;
      a_flush     = (c == 2);
      step();
      a_touch_en = 1'b0;
      a_flush    = 1'b0;
    end
    total++;
    if (busy_cnt != S0) $display("FAIL flush_len: busy cycles %0d expected %0d", busy_cnt, S0);
    else passed++;
    a_query_set = 2'd0;
    #1;
    total++;
    if (a_victim !== 2'd0) $display("FAIL flush_touch_drop: victim %0d expected 0", a_victim);
    else passed++;
  endtask

  task automatic test_reset_mid_sweep();
    int busy_cnt;
    for (int s = 0; s < S0; s++) begin
      a_touch_en  = 1'b1;
      a_touch_set = 2'(s);
      a_touch_way = 2'd1;
      step();
    end
    a_touch_en = 1'b0;
    a_flush    = 1'b1;
    step();
    a_flush = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int s = 0; s < S0; s++) begin
      a_query_set = 2'(s);
      #1;
      total++;
      if (a_victim !== 2'(exp_way(0, s, {4'hF, a_valid})))
        $display("FAIL rst_mid_hold set %0d: victim %0d expected %0d", s, a_victim, exp_way(0, s, {4'hF, a_valid}));
      else passed++;
    end
    busy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (a_busy === 1'b1) busy_cnt++;
      step();
    end
    total++;
    if (busy_cnt != S0) $display("FAIL rst_mid_len: busy cycles %0d expected %0d", busy_cnt, S0);
    else passed++;
    for (int s = 0; s < S0; s++) begin
      a_query_set = 2'(s);
      #1;
      total++;
      if (a_victim !== 2'd0) $display("FAIL rst_mid_clear set %0d: victim %0d expected 0", s, a_victim);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int ea, eb;
    for (int i = 0; i < 300; i++) begin
      a_touch_en  = 1'($urandom_range(0, 1));
      a_touch_set = 2'($urandom_range(0, 3));
      a_touch_way = 2'($urandom_range(0, 3));
      a_query_set = 2'($urandom_range(0, 3));
      a_valid     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      a_flush     = ($urandom_range(0, 59) == 0);
      b_touch_en  = 1'($urandom_range(0, 1));
      b_touch_set = 1'($urandom_range(0, 1));
      b_touch_way = 3'($urandom_range(0, 7));
      b_query_set = 1'($urandom_range(0, 1));
      b_valid     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      b_flush     = ($urandom_range(0, 59) == 0);
      #1;
      ea = exp_way(0, int'(a_query_set), {4'hF, a_valid});
      eb = exp_way(1, int'(b_query_set), b_valid);
      total++;
      if (a_victim !== 2'(ea) || a_inv !== exp_inv(0, {4'hF, a_valid}) || a_busy !== (sweep[0] >= 0))
        $display("FAIL random_a %0d: victim %0d inv %b busy %b expected %0d %b %b", i, a_victim, a_inv, a_busy,
                 ea, exp_inv(0, {4'hF, a_valid}), sweep[0] >= 0);
      else passed++;
      total++;
      if (b_victim !== 3'(eb) || b_inv !== exp_inv(1, b_valid) || b_busy !== (sweep[1] >= 0))
        $display("FAIL random_b %0d: victim %0d inv %b busy %b expected %0d %b %b", i, b_victim, b_inv, b_busy,
                 eb, exp_inv(1, b_valid), sweep[1] >= 0);
      else passed++;
      step();
    end
    a_touch_en = 1'b0;
    a_flush    = 1'b0;
    b_touch_en = 1'b0;
    b_flush    = 1'b0;
  endtask

  initial begin
    passed      = 0;
    total       = 0;
    now_t       = 0;
    sweep       = '{-1, -1};
    rst_n       = 1'b0;
    a_touch_en  = 1'b0;
    a_touch_set = 2'd0;
    a_touch_way = 2'd0;
    a_query_set = 2'd0;
    a_valid     = 4'hF;
    a_flush     = 1'b0;
    b_touch_en  = 1'b0;
    b_touch_set = 1'b0;
    b_touch_way = 3'd0;
    b_query_set = 1'b0;
    b_valid     = 8'hFF;
    b_flush     = 1'b0;
    test_reset();
    test_assoc8();
    test_touch_order();
    test_sets();
    test_invalid();
    test_flush();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
